// File: rtl/dice_roll_unit_if.sv
// Signal bundle between the roll pushbutton front end and the craps game logic.
// Latency: none (wires only).
// Backpressure: none; roll is a fire-and-forget strobe.
//
// master : the side that drives roll_btn / game_state (and the optional force
//          inputs) and observes the captured dice, sum, point, roll and busy.
// slave  : dice_roll_unit itself.
// DICE_FORCE_EN adds force_valid / force_a / force_b for deterministic dice.
interface dice_roll_unit_if;
    logic       roll_btn;
    logic [1:0] game_state;
`ifdef DICE_FORCE_EN
    logic       force_valid;
    logic [2:0] force_a;
    logic [2:0] force_b;
`endif
    logic [2:0] die_a;
    logic [2:0] die_b;
    logic [3:0] sum;
    logic [3:0] point;
    logic       roll;
    logic       busy;

`ifdef DICE_FORCE_EN
    modport master (
        output roll_btn, game_state, force_valid, force_a, force_b,
        input  die_a, die_b, sum, point, roll, busy
    );
    modport slave (
        input  roll_btn, game_state, force_valid, force_a, force_b,
        output die_a, die_b, sum, point, roll, busy
    );
`else
    modport master (
        output roll_btn, game_state,
        input  die_a, die_b, sum, point, roll, busy
    );
    modport slave (
        input  roll_btn, game_state,
        output die_a, die_b, sum, point, roll, busy
    );
`endif
endinterface

// File: rtl/dice_roll_unit.sv
// Debounces the roll button, captures two dice from free-running counters, strobes roll.
// Latency: clean press to roll=1 in DEBOUNCE_CYCLES + 4 clocks; roll is STROBE_CYCLES wide.
// Backpressure: none; presses while busy (strobe or release debounce) are ignored.
//
// Ports:
//   clk, reset (async, active high)
//   bus.roll_btn   raw, bouncy, asynchronous pushbutton
//   bus.game_state downstream state (00 init, 01 reroll, 10 win, 11 lose)
//   bus.die_a/die_b captured dice 1..6, bus.sum 2..12, bus.point come-out sum or 0
//   bus.roll       registered strobe, bus.busy high whenever the FSM is not idle
// Optional macro DICE_FORCE_EN: adds force_valid/force_a/force_b; when force_valid
// is high during capture the clamped forced values replace the counters.
module dice_roll_unit #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int STROBE_CYCLES   = 2
) (
    input  logic             clk,
    input  logic             reset,
    dice_roll_unit_if.slave  bus
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int ST_W = $clog2(STROBE_CYCLES + 1);

    // The IDLE cycle that first sees btn_s=1 counts as the first stable
    // cycle, so DEBOUNCE itself needs one fewer.
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 2);
    // Release debounce counts every low cycle inside WAIT_RELEASE.
    localparam logic [DB_W-1:0] WR_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [ST_W-1:0] ST_LAST = ST_W'(STROBE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEBOUNCE,
        S_CAPTURE,
        S_STROBE,
        S_WAIT_RELEASE
    } state_t;

    typedef struct packed {
        logic [2:0] die_a;
        logic [2:0] die_b;
        logic [3:0] sum;
        logic [3:0] point;
    } roll_res_t;

    // ------------------------------------------------------------------
    // Button synchronizer
    // ------------------------------------------------------------------
    logic btn_m;
    logic btn_s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_m <= 1'b0;
            btn_s <= 1'b0;
        end else begin
            btn_m <= bus.roll_btn;
            btn_s <= btn_m;
        end
    end

    // ------------------------------------------------------------------
    // Free-running dice counters: cnt_b advances once per full lap of
    // cnt_a, so over 36 clocks every (a,b) pair appears exactly once.
    // ------------------------------------------------------------------
    logic [2:0] cnt_a;
    logic [2:0] cnt_b;
    logic       a_wrap;

    assign a_wrap = (cnt_a == 3'd6);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_a <= 3'd1;
            cnt_b <= 3'd1;
        end else begin
            cnt_a <= a_wrap ? 3'd1 : cnt_a + 3'd1;
            if (a_wrap) begin
                cnt_b <= (cnt_b == 3'd6) ? 3'd1 : cnt_b + 3'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Dice source selection
    // ------------------------------------------------------------------
    logic [2:0] src_a;
    logic [2:0] src_b;
    logic [3:0] sum_new;

`ifdef DICE_FORCE_EN
    // Out-of-range forced faces are pulled to the nearest legal face.
    function automatic logic [2:0] clamp_die(input logic [2:0] v);
        if (v == 3'd0) begin
            return 3'd1;
        end else if (v == 3'd7) begin
            return 3'd6;
        end else begin
            return v;
        end
    endfunction

    always_comb begin
        src_a = cnt_a;
        src_b = cnt_b;
        if (bus.force_valid) begin
            src_a = clamp_die(bus.force_a);
            src_b = clamp_die(bus.force_b);
        end
    end
`else
    assign src_a = cnt_a;
    assign src_b = cnt_b;
`endif

    // Max 6+6=12 fits in 4 bits.
    assign sum_new = {1'b0, src_a} + {1'b0, src_b};

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t          state;
    state_t          state_nxt;
    logic [DB_W-1:0] dcnt;
    logic [DB_W-1:0] dcnt_nxt;
    logic [ST_W-1:0] scnt;
    logic [ST_W-1:0] scnt_nxt;
    logic            cap_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
            dcnt  <= '0;
            scnt  <= '0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            scnt  <= scnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        scnt_nxt  = scnt;
        cap_en    = 1'b0;
        case (state)
            S_IDLE: begin
                dcnt_nxt = '0;
                if (btn_s) begin
                    state_nxt = S_DEBOUNCE;
                end
            end
            S_DEBOUNCE: begin
                if (!btn_s) begin
                    state_nxt = S_IDLE;
                end else if (dcnt == DB_LAST) begin
                    state_nxt = S_CAPTURE;
                end else begin
                    dcnt_nxt = dcnt + DB_W'(1);
                end
            end
            S_CAPTURE: begin
                cap_en    = 1'b1;
                scnt_nxt  = '0;
                state_nxt = S_STROBE;
            end
            S_STROBE: begin
                if (scnt == ST_LAST) begin
                    dcnt_nxt  = '0;
                    state_nxt = S_WAIT_RELEASE;
                end else begin
                    scnt_nxt = scnt + ST_W'(1);
                end
            end
            S_WAIT_RELEASE: begin
                // Any high sample means the button is still (or again)
                // pressed: start the release count over.
                if (btn_s) begin
                    dcnt_nxt = '0;
                end else if (dcnt == WR_LAST) begin
                    state_nxt = S_IDLE;
                end else begin
                    dcnt_nxt = dcnt + DB_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Captured results; game_state only matters on the capture clock.
    // ------------------------------------------------------------------
    roll_res_t res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res <= '0;
        end else if (cap_en) begin
            res.die_a <= src_a;
            res.die_b <= src_b;
            res.sum   <= sum_new;
            case (bus.game_state)
                2'b00:   res.point <= sum_new;
                2'b01:   res.point <= res.point;
                default: res.point <= 4'd0;
            endcase
        end
    end

    // roll is a flop that follows the STROBE state one clock late. This puts
    // the capture edge a full clock ahead of roll's rising edge, and the
    // flop's async reset drops roll the moment reset asserts.
    logic roll_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            roll_q <= 1'b0;
        end else begin
            roll_q <= (state == S_STROBE);
        end
    end

    assign bus.die_a = res.die_a;
    assign bus.die_b = res.die_b;
    assign bus.sum   = res.sum;
    assign bus.point = res.point;
    assign bus.roll  = roll_q;
    assign bus.busy  = (state != S_IDLE);

endmodule

// File: tb/tb_dice_roll_unit.sv
// Self-checking bench for dice_roll_unit: random presses, bounces and resets
// compared against a behavioural model of the dice, sum and point rules.
// Covers the force path as well when DICE_FORCE_EN is defined.
module tb_dice_roll_unit;

    localparam int DB = 16;
    localparam int ST = 2;
    localparam int LAT = DB + 4;

    logic clk;
    logic reset;
    int   cyc;
    int   n_chk;
    int   n_pass;

    logic [2:0] mdl_a;
    logic [2:0] mdl_b;
    logic [3:0] mdl_sum;
    logic [3:0] mdl_point;

    dice_roll_unit_if bus ();

    dice_roll_unit #(
        .DEBOUNCE_CYCLES(DB),
        .STROBE_CYCLES  (ST)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Clock edges since reset was last released.
    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Dice faces after k clock edges: A cycles every clock, B every six.
    function automatic logic [2:0] face_a(input int k);
        return 3'((k % 6) + 1);
    endfunction

    function automatic logic [2:0] face_b(input int k);
        return 3'(((k / 6) % 6) + 1);
    endfunction

    function automatic logic [2:0] legal_face(input logic [2:0] v);
        if (v < 3'd1) return 3'd1;
        if (v > 3'd6) return 3'd6;
        return v;
    endfunction

    task automatic set_force(input logic fv, input logic [2:0] fa, input logic [2:0] fb);
`ifdef DICE_FORCE_EN
        bus.force_valid = fv;
        bus.force_a     = fa;
        bus.force_b     = fb;
`endif
    endtask

    // One full press: hold for `hold` clocks then release; optionally
    // re-press briefly while the release is being debounced.
    task automatic do_roll(input logic [1:0] gs, input logic fv, input logic [2:0] fa,
                           input logic [2:0] fb, input int hold, input bit rebounce);
        int   p;
        int   rises;
        int   highs;
        int   rise_at;
        int   rel_end;
        int   total;
        logic prev;
        bit   forced;
        forced = 1'b0;
`ifdef DICE_FORCE_EN
        forced = fv;
`endif
        @(posedge clk); #1;
        p = cyc;
        bus.roll_btn   = 1'b1;
        bus.game_state = 2'($urandom);
        set_force(fv, fa, fb);
        rel_end = rebounce ? hold + 10 : hold;
        total   = rel_end + DB + 6;
        rises = 0; highs = 0; rise_at = -1; prev = 1'b0;
        for (int i = 1; i <= total; i++) begin
            @(posedge clk); #1;
            if (!prev && bus.roll) begin
                rises++;
                if (rise_at < 0) rise_at = i;
            end
            if (bus.roll) highs++;
            prev = bus.roll;
            if (i == LAT - 3) bus.game_state = gs;
            if (i == LAT - 1) begin
                // Capture happened on this edge with counters from p+LAT-2 edges.
                if (forced) begin
                    mdl_a = legal_face(fa);
                    mdl_b = legal_face(fb);
                end else begin
                    mdl_a = face_a(p + LAT - 2);
                    mdl_b = face_b(p + LAT - 2);
                end
                mdl_sum = 4'(mdl_a) + 4'(mdl_b);
                if (gs == 2'b00)      mdl_point = mdl_sum;
                else if (gs != 2'b01) mdl_point = 4'd0;
                check("sum_before_roll", bus.sum, mdl_sum);
                check("roll_low_at_capture", bus.roll, 0);
                bus.game_state = 2'($urandom);
                set_force(1'($urandom), 3'($urandom), 3'($urandom));
            end
            if (i == hold) bus.roll_btn = 1'b0;
            if (rebounce && i == hold + 6)  bus.roll_btn = 1'b1;
            if (rebounce && i == hold + 10) bus.roll_btn = 1'b0;
            if (!rebounce && i == hold + DB + 1) check("busy_release_window", bus.busy, 1);
        end
        check("roll_rise_offset", rise_at, LAT);
        check("roll_width", highs, ST);
        check("roll_count", rises, 1);
        check("die_a", bus.die_a, mdl_a);
        check("die_b", bus.die_b, mdl_b);
        check("sum", bus.sum, mdl_sum);
        check("point", bus.point, mdl_point);
        check("busy_after_release", bus.busy, 0);
    endtask

    // High / low / high pattern, every high run too short to be accepted.
    task automatic do_bounce(input int hi1, input int lo, input int hi2);
        int rises;
        int busy_seen;
        rises = 0; busy_seen = 0;
        @(posedge clk); #1;
        bus.game_state = 2'($urandom);
        for (int i = 0; i < hi1 + lo + hi2 + DB + 4; i++) begin
            bus.roll_btn = (i < hi1) || (i >= hi1 + lo && i < hi1 + lo + hi2);
            @(posedge clk); #1;
            if (bus.roll) rises++;
            if (bus.busy) busy_seen++;
        end
        check("bounce_no_roll", rises, 0);
        check("bounce_busy_seen", busy_seen > 0, 1);
        check("bounce_idle", bus.busy, 0);
        check("bounce_sum_kept", bus.sum, mdl_sum);
        check("bounce_point_kept", bus.point, mdl_point);
    endtask

    task automatic do_reset_mid_strobe();
        @(posedge clk); #1;
        bus.roll_btn   = 1'b1;
        bus.game_state = 2'b00;
        set_force(1'b0, 3'd0, 3'd0);
        repeat (LAT) @(posedge clk);
        #1;
        check("roll_before_reset", bus.roll, 1);
        #3;
        reset = 1'b1;
        #1;
        mdl_sum = 4'd0; mdl_point = 4'd0;
        check("rst_roll", bus.roll, 0);
        check("rst_sum", bus.sum, 0);
        check("rst_point", bus.point, 0);
        check("rst_dice", {bus.die_a, bus.die_b}, 0);
        check("rst_busy", bus.busy, 0);
        @(posedge clk); #2;
        reset        = 1'b0;
        bus.roll_btn = 1'b0;
        repeat (DB + 4) @(posedge clk);
    endtask

    initial begin
        n_chk = 0; n_pass = 0;
        mdl_a = 3'd0; mdl_b = 3'd0; mdl_sum = 4'd0; mdl_point = 4'd0;
        reset          = 1'b1;
        bus.roll_btn   = 1'b0;
        bus.game_state = 2'b00;
        set_force(1'b0, 3'd0, 3'd0);
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;

        // Idle after reset: everything zero; internal dice counters step as modelled.
        for (int i = 0; i < 100; i++) begin
            if (i < 12) begin
                check("cnt_a_seq", dut.cnt_a, face_a(cyc));
                check("cnt_b_seq", dut.cnt_b, face_b(cyc));
            end
            check("idle_outputs_zero",
                  {bus.die_a, bus.die_b, bus.sum, bus.point, bus.roll, bus.busy}, 0);
            @(posedge clk); #1;
        end

`ifdef DICE_FORCE_EN
        do_roll(2'b00, 1'b1, 3'd3, 3'd4, 40, 1'b0);
        do_roll(2'b00, 1'b1, 3'd2, 3'd3, 30, 1'b0);
        do_roll(2'b01, 1'b1, 3'd6, 3'd6, 30, 1'b0);
        do_roll(2'b10, 1'b1, 3'd1, 3'd1, 30, 1'b0);
        do_roll(2'b00, 1'b1, 3'd0, 3'd7, 30, 1'b0);
`endif
        do_roll(2'b00, 1'b0, 3'd0, 3'd0, 40, 1'b0);
        do_roll(2'b01, 1'b0, 3'd0, 3'd0, 25, 1'b0);

        do_reset_mid_strobe();
        do_roll(2'b00, 1'b0, 3'd0, 3'd0, 30, 1'b0);

        for (int r = 0; r < 12; r++) begin
            do_roll(2'($urandom), 1'($urandom), 3'($urandom), 3'($urandom),
                    $urandom_range(22, 45), 1'($urandom));
        end

        do_bounce(10, 3, 10);
        do_bounce(DB - 1, 1, DB - 1);
        for (int r = 0; r < 3; r++) begin
            do_bounce($urandom_range(1, DB - 2), $urandom_range(1, 4), $urandom_range(1, DB - 2));
        end
        do_roll(2'b00, 1'b0, 3'd0, 3'd0, 24, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
